regfile_sb: RTL and testbench

- Parametrised successor of the integer register file: configurable width, depth and read-port count.
- Two write ports: port 0 for single-cycle ALU writeback, port 1 for long-latency load/mul/div writeback.
- Built-in per-register busy scoreboard and same-cycle write-to-read bypass.
- Sits between decode/issue and writeback; its issue-stall output replaces the external hazard unit.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 69 ++++++
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing constants and write-port payload type for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_MAX   = 4;
  localparam int unsigned XLEN_MAX  = 64;
  localparam int unsigned AW_MAX    = 8;

  function automatic int unsigned addr_w(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int unsigned AW_DEF = addr_w(NREGS_DEF);

  // Write request sized for the widest supported configuration; narrower ports zero-extend.
  typedef struct packed {
    logic                we;
    logic [AW_MAX-1:0]   wa;
    logic [XLEN_MAX-1:0] wd;
  } wreq_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for long-latency destinations and the resulting issue stall.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned AW     = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rs,
  input  logic [NRD-1:0]    rs_used,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              iss_long,
  output logic [NREGS-1:0]  busy,
  output logic              stall_c
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_c;
  logic [NREGS-1:0] clr_c;
  logic [AW-1:0]    rs_a [NRD];
  logic [NRD-1:0]   hazard_c;
  logic             waw_c;

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rs_a[i] = rs[i*AW +: AW];
    end
  end

  // A long-latency writeback arriving this cycle only hides the hazard when it is forwarded.
  always_comb begin
    hazard_c = '0;
    for (int i = 0; i < NRD; i++) begin
      hazard_c[i] = rs_used[i] && busy_q[rs_a[i]] && !(BYPASS && we1 && (wa1 == rs_a[i]));
    end
    waw_c   = iss_valid && (iss_rd != '0) && busy_q[iss_rd] && !(BYPASS && we1 && (wa1 == iss_rd));
    stall_c = (|hazard_c) || waw_c;
  end

  // Set has priority over a same-cycle clear; register 0 never becomes busy.
  always_comb begin
    set_c  = '0;
    clr_c  = '0;
    busy_d = '0;
    for (int r = 1; r < NREGS; r++) begin
      set_c[r]  = iss_valid && iss_long && !stall_c && (iss_rd == AW'(r));
      clr_c[r]  = we1 && (wa1 == AW'(r));
      busy_d[r] = set_c[r] | (busy_q[r] & ~clr_c[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two write ports, same-cycle bypass and a built-in busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs,
  input  logic [NRD-1:0]      rs_used,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                iss_long,
  output logic                stall,
  output logic [NREGS-1:0]    busy,
  output logic                wr_conflict
);

  wreq_t           w0;
  wreq_t           w1;
  logic            unused_wreq;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [AW-1:0]   rs_a   [NRD];

  always_comb begin
    w0    = '0;
    w0.we = we0;
    w0.wa = AW_MAX'(wa0);
    w0.wd = XLEN_MAX'(wd0);
    w1    = '0;
    w1.we = we1;
    w1.wa = AW_MAX'(wa1);
    w1.wd = XLEN_MAX'(wd1);
  end

  // Zero-extension bits above the configured widths carry no information.
  assign unused_wreq = ^{w0, w1};

  // Port 1 wins a same-address collision; register 0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w1.we && (w1.wa == AW_MAX'(r))) begin
          regs_q[r] <= XLEN'(w1.wd);
        end else if (w0.we && (w0.wa == AW_MAX'(r))) begin
          regs_q[r] <= XLEN'(w0.wd);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= w0.we && w1.we && (w0.wa == w1.wa) && (w1.wa != '0);
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rs_a[i] = rs[i*AW +: AW];
    end
  end

  // Combinational read with optional forwarding of this cycle's write data.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rs_a[i] == '0) begin
        rdata[i*XLEN +: XLEN] = '0;
      end else if (BYPASS && w1.we && (w1.wa == AW_MAX'(rs_a[i]))) begin
        rdata[i*XLEN +: XLEN] = XLEN'(w1.wd);
      end else if (BYPASS && w0.we && (w0.wa == AW_MAX'(rs_a[i]))) begin
        rdata[i*XLEN +: XLEN] = XLEN'(w0.wd);
      end else begin
        rdata[i*XLEN +: XLEN] = regs_q[rs_a[i]];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rs        (rs),
    .rs_used   (rs_used),
    .we1       (we1),
    .wa1       (wa1),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_long  (iss_long),
    .busy      (busy),
    .stall_c   (stall)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench driving a forwarding and a non-forwarding register file with identical stimulus.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk;
  logic                reset;
  logic [NRD*AW-1:0]   rs;
  logic [NRD-1:0]      rs_used;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_long;

  logic [NRD*XLEN-1:0] rdata_a, rdata_b;
  logic                stall_a, stall_b;
  logic [NREGS-1:0]    busy_a, busy_b;
  logic                wrc_a, wrc_b;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rs(rs), .rs_used(rs_used), .rdata(rdata_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_long(iss_long),
    .stall(stall_a), .busy(busy_a), .wr_conflict(wrc_a)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rs(rs), .rs_used(rs_used), .rdata(rdata_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_long(iss_long),
    .stall(stall_b), .busy(busy_b), .wr_conflict(wrc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs = '0; rs_used = '0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_rd = '0; iss_long = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    #1;
    chk("reset_rdata_a", 64'(rdata_a), 64'h0);
    chk("reset_busy_a",  64'(busy_a),  64'h0);
    chk("reset_wrc_a",   64'(wrc_a),   64'h0);
    reset = 1'b0;
    tick();

    // ALU write to x3, forwarded in the write cycle only when bypass is enabled
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF; rs = {5'd0, 5'd3};
    #1;
    chk("wr3_fwd_a",   64'(rdata_a[31:0]), 64'hDEADBEEF);
    chk("wr3_nofwd_b", 64'(rdata_b[31:0]), 64'h0);
    tick();
    idle(); rs = {5'd3, 5'd3};
    #1;
    chk("rd3_a", 64'(rdata_a), 64'hDEADBEEF_DEADBEEF);
    chk("rd3_b", 64'(rdata_b), 64'hDEADBEEF_DEADBEEF);

    // Writes to x0 are dropped and never forwarded
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; rs = '0;
    #1;
    chk("x0_fwd_a", 64'(rdata_a[31:0]), 64'h0);
    tick();
    idle();
    #1;
    chk("x0_rd_a", 64'(rdata_a[31:0]), 64'h0);

    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA5A5A5A5; rs = {5'd0, 5'd7};
    #1;
    chk("byp7_a", 64'(rdata_a[31:0]), 64'hA5A5A5A5);
    chk("byp7_b", 64'(rdata_b[31:0]), 64'h0);
    tick();
    idle();

    // Long-latency op to x9: busy, reader stalls until the writeback
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9;
    #1;
    chk("iss9_stall_a", 64'(stall_a), 64'h0);
    tick();
    idle(); rs = {5'd0, 5'd9}; rs_used = 2'b01;
    #1;
    chk("busy9_a",  64'(busy_a),  64'h200);
    chk("busy9_b",  64'(busy_b),  64'h200);
    chk("raw9_a",   64'(stall_a), 64'h1);
    chk("raw9_b",   64'(stall_b), 64'h1);
    tick();
    #1;
    chk("raw9_hold_a", 64'(stall_a), 64'h1);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55;
    #1;
    chk("wb9_stall_a", 64'(stall_a), 64'h0);
    chk("wb9_rd_a",    64'(rdata_a[31:0]), 64'h55);
    chk("wb9_stall_b", 64'(stall_b), 64'h1);
    chk("wb9_rd_b",    64'(rdata_b[31:0]), 64'h0);
    tick();
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    #1;
    chk("post9_busy_a",  64'(busy_a),  64'h0);
    chk("post9_busy_b",  64'(busy_b),  64'h0);
    chk("post9_stall_b", 64'(stall_b), 64'h0);
    chk("post9_rd_b",    64'(rdata_b[31:0]), 64'h55);
    idle();

    // Same-cycle set and clear of x4
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd4;
    tick();
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h77;
    #1;
    chk("sc4_stall_a", 64'(stall_a), 64'h0);
    chk("sc4_stall_b", 64'(stall_b), 64'h1);
    tick();
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0;
    #1;
    chk("sc4_busy_a", 64'(busy_a), 64'h10);
    chk("sc4_busy_b", 64'(busy_b), 64'h0);
    tick();
    idle();
    #1;
    chk("clr4_busy_a", 64'(busy_a), 64'h0);

    // WAW on busy x9 stalls even for a short-latency issue
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9;
    tick();
    iss_long = 1'b0;
    #1;
    chk("waw9_stall_a", 64'(stall_a), 64'h1);
    chk("waw9_stall_b", 64'(stall_b), 64'h1);
    iss_valid = 1'b0; we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h66;
    tick();
    idle();

    // Dual write to x12: port 1 wins, one-cycle conflict pulse
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h2; rs = {5'd0, 5'd12};
    #1;
    chk("dual_fwd_a", 64'(rdata_a[31:0]), 64'h2);
    tick();
    idle(); rs = {5'd0, 5'd12};
    #1;
    chk("dual_wrc_a", 64'(wrc_a), 64'h1);
    chk("dual_wrc_b", 64'(wrc_b), 64'h1);
    chk("dual_rd_b",  64'(rdata_b[31:0]), 64'h2);
    tick();
    #1;
    chk("dual_pulse_a", 64'(wrc_a), 64'h0);
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h1; wd1 = 32'h2;
    tick();
    idle();
    #1;
    chk("dual_x0_wrc_a", 64'(wrc_a), 64'h0);

    // Async reset between clock edges drops pending x5 and clears storage
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd5;
    tick();
    idle(); rs = {5'd3, 5'd12};
    #1;
    chk("pre_rst_busy_a", 64'(busy_a), 64'h20);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_rd_a",   64'(rdata_a), 64'h0);
    chk("mid_rst_rd_b",   64'(rdata_b), 64'h0);
    chk("mid_rst_busy_a", 64'(busy_a),  64'h0);
    chk("mid_rst_busy_b", 64'(busy_b),  64'h0);
    tick();
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h99;
    tick();
    idle(); rs = {5'd0, 5'd5};
    #1;
    chk("late_wb5_rd_b",   64'(rdata_b[31:0]), 64'h99);
    chk("late_wb5_busy_a", 64'(busy_a), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
